// File: rtl/iddr_deser.sv
// IDDR input deserializer: hunts for SYNC at even/odd bit phase, then packs WIDTH-bit words
// onto a valid/ready output. Define IDDR_DESER_STATS_EN to add word_cnt/sync_cnt counters.
module iddr_deser #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SYNC  = 8'hA5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_rise,
  input  logic             d_fall,
  input  logic             en,
  input  logic             resync,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             locked,
  output logic             phase,
  output logic             overflow
`ifdef IDDR_DESER_STATS_EN
  ,
  output logic [15:0]      word_cnt,
  output logic [7:0]       sync_cnt
`endif
);

  // Handshake: a word transfers on any clk edge where out_valid && out_ready; out_data
  // and out_valid stay stable while out_valid && !out_ready.

  localparam int BEAT_W = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(WIDTH / 2 - 1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [WIDTH:0]    sr_q, sr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              phase_q, phase_d;
  logic              overflow_q, overflow_d;
`ifdef IDDR_DESER_STATS_EN
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic [7:0]        sync_cnt_q, sync_cnt_d;
`endif

  logic [WIDTH-1:0]  win_e, win_o, word;
  logic              word_done;

  assign win_e = sr_q[WIDTH-1:0];
  assign win_o = sr_q[WIDTH:1];
  assign word  = phase_q ? win_o : win_e;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    beat_d      = beat_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    phase_d     = phase_q;
    overflow_d  = overflow_q;
    word_done   = 1'b0;
`ifdef IDDR_DESER_STATS_EN
    word_cnt_d  = word_cnt_q;
    sync_cnt_d  = sync_cnt_q;
`endif

    if (en) sr_d = {sr_q[WIDTH-2:0], d_rise, d_fall};

    if (!en || resync) begin
      state_d = HUNT;
      beat_d  = '0;
    end else begin
      case (state_q)
        HUNT: begin
          // Even alignment is tested first so it wins when both windows match.
          if (win_e == SYNC) begin
            state_d = LOCKED;
            phase_d = 1'b0;
            beat_d  = '0;
          end else if (win_o == SYNC) begin
            state_d = LOCKED;
            phase_d = 1'b1;
            beat_d  = '0;
          end
        end
        LOCKED: begin
          if (beat_q == BEAT_LAST) begin
            beat_d    = '0;
            word_done = 1'b1;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (word_done && word != SYNC) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = word;
        out_valid_d = 1'b1;
`ifdef IDDR_DESER_STATS_EN
        if (word_cnt_q != 16'hFFFF) word_cnt_d = word_cnt_q + 16'd1;
`endif
      end else begin
        overflow_d = 1'b1;
      end
    end
`ifdef IDDR_DESER_STATS_EN
    if (word_done && word == SYNC && sync_cnt_q != 8'hFF) sync_cnt_d = sync_cnt_q + 8'd1;
`endif

    if (resync) begin
      overflow_d = 1'b0;
`ifdef IDDR_DESER_STATS_EN
      word_cnt_d = '0;
      sync_cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      sr_q        <= '0;
      beat_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      phase_q     <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef IDDR_DESER_STATS_EN
      word_cnt_q  <= '0;
      sync_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      beat_q      <= beat_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      phase_q     <= phase_d;
      overflow_q  <= overflow_d;
`ifdef IDDR_DESER_STATS_EN
      word_cnt_q  <= word_cnt_d;
      sync_cnt_q  <= sync_cnt_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign locked    = (state_q == LOCKED);
  assign phase     = phase_q;
  assign overflow  = overflow_q;
`ifdef IDDR_DESER_STATS_EN
  assign word_cnt  = word_cnt_q;
  assign sync_cnt  = sync_cnt_q;
`endif

endmodule

// File: tb/tb_iddr_deser.sv
// Bench for iddr_deser: directed alignment/handshake cases plus random bit streams checked
// against a bit-stream reference model through an expected-word queue.
module tb_iddr_deser;
  localparam int W = 8;
  localparam logic [W-1:0] S = 8'hA5;

  logic         clk = 1'b0;
  logic         rst_n, d_rise, d_fall, en, resync, out_ready;
  logic [W-1:0] out_data;
  logic         out_valid, locked, phase, overflow;
`ifdef IDDR_DESER_STATS_EN
  logic [15:0]  word_cnt;
  logic [7:0]   sync_cnt;
`endif

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];
  bit           stream_q[$];
  int           exp_words, exp_syncs;

  iddr_deser #(.WIDTH(W), .SYNC(S)) dut (
    .clk(clk), .rst_n(rst_n), .d_rise(d_rise), .d_fall(d_fall), .en(en),
    .resync(resync), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .locked(locked), .phase(phase), .overflow(overflow)
`ifdef IDDR_DESER_STATS_EN
    , .word_cnt(word_cnt), .sync_cnt(sync_cnt)
`endif
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pair(input logic r, input logic f);
    d_rise = r;
    d_fall = f;
    tick();
  endtask

  task automatic send_bits(input logic [63:0] v, input int nb);
    for (int i = nb - 1; i > 0; i -= 2) drive_pair(v[i], v[i-1]);
  endtask

  task automatic send_word(input logic [W-1:0] w);
    send_bits({56'd0, w}, W);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; resync = 1'b0; d_rise = 1'b0; d_fall = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: every transfer pops one expected word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL word: got %0h expected none (queue empty)", out_data);
      end else begin
        check("word", out_data, exp_q.pop_front());
      end
    end
  end

  // Reference model: the wire is W zero bits (cleared register) followed by stream_q.
  function automatic logic [W-1:0] win(input int e);
    logic [W-1:0] v;
    int idx;
    v = '0;
    for (int i = 0; i < W; i++) begin
      idx = e - W + i - W;
      v = {v[W-2:0], (idx >= 0) ? stream_q[idx] : 1'b0};
    end
    return v;
  endfunction

  // Each clk with n wire bits held, HUNT tries the windows ending at n and n-1; once locked,
  // words are consecutive W-bit slices after the SYNC, judged once they are fully held.
  task automatic model_stream();
    int p, n, nxt;
    bit lk;
    p = stream_q.size() / 2;
    lk = 1'b0;
    nxt = 0;
    for (int k = 0; k < p; k++) begin
      n = W + 2 * k;
      if (!lk) begin
        if (win(n) == S) begin lk = 1'b1; nxt = n + W; end
        else if (win(n - 1) == S) begin lk = 1'b1; nxt = n - 1 + W; end
      end else if (n >= nxt) begin
        if (win(nxt) != S) begin exp_q.push_back(win(nxt)); exp_words++; end
        else exp_syncs++;
        nxt += W;
      end
    end
  endtask

  task automatic push_word_bits(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) stream_q.push_back(w[i]);
  endtask

  initial begin
    out_ready = 1'b1;
    do_reset();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_locked", locked, 0);
    check("rst_phase", phase, 0);
    check("rst_overflow", overflow, 0);

    // Even alignment, latency of one clk after the final pair
    en = 1'b1;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    send_word(S);
    check("t1_prelock", locked, 0);
    send_word(8'h3C);
    check("t1_locked", locked, 1);
    check("t1_phase", phase, 0);
    check("t1_not_early", out_valid, 0);
    drive_pair(1'b1, 1'b1);
    check("t1_latency_valid", out_valid, 1);
    check("t1_latency_data", out_data, 8'h3C);
    drive_pair(1'b0, 1'b0);
    drive_pair(1'b0, 1'b0);
    drive_pair(1'b1, 1'b1);
    drive_pair(1'b0, 1'b0);
    en = 1'b0;
    tick(); tick();
    check("t1_drain", exp_q.size(), 0);

    // Odd alignment after one pad bit
    do_reset();
    en = 1'b1;
    exp_q.push_back(8'h5A);
    send_bits({44'd0, 1'b0, 8'hA5, 8'h5A, 3'b000}, 20);
    check("t2_locked", locked, 1);
    check("t2_phase", phase, 1);
    check("t2_overflow", overflow, 0);
    en = 1'b0;
    tick(); tick();
    check("t2_drain", exp_q.size(), 0);

    // Stall: output held, later words dropped, overflow sticky
    do_reset();
    en = 1'b1;
    out_ready = 1'b0;
    exp_q.push_back(8'h3C);
    send_word(S);
    send_word(8'h3C);
    send_word(8'hC3);
    check("t3_no_drop_yet", overflow, 0);
    send_word(8'hF0);
    check("t3_overflow", overflow, 1);
    check("t3_hold_data", out_data, 8'h3C);
    check("t3_hold_valid", out_valid, 1);
    drive_pair(1'b0, 1'b0);
    check("t3_hold_data2", out_data, 8'h3C);
    en = 1'b0;
    out_ready = 1'b1;
    tick();
    check("t3_valid_clear", out_valid, 0);
    check("t3_overflow_sticky", overflow, 1);
    check("t3_drain", exp_q.size(), 0);

    // Resync mid-word: drops lock, clears overflow, relocks on next SYNC
    en = 1'b1;
    exp_q.push_back(8'h11);
    send_word(S);
    send_word(8'h11);
    drive_pair(1'b0, 1'b0);
    resync = 1'b1;
    drive_pair(1'b0, 1'b0);
    resync = 1'b0;
    check("t5_locked_drop", locked, 0);
    check("t5_overflow_clr", overflow, 0);
    exp_q.push_back(8'h77);
    send_word(8'h00);
    send_word(S);
    send_word(8'h77);
    drive_pair(1'b0, 1'b0);
    check("t5_relocked", locked, 1);
    en = 1'b0;
    tick(); tick();
    check("t5_drain", exp_q.size(), 0);
`ifdef IDDR_DESER_STATS_EN
    check("t5_word_cnt", word_cnt, 1);
`endif

    // SYNC filler while locked is discarded
    do_reset();
    en = 1'b1;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_word(S);
    send_word(8'h11);
    send_word(S);
    send_word(8'h22);
    drive_pair(1'b0, 1'b0);
    en = 1'b0;
    tick(); tick();
    check("t4_drain", exp_q.size(), 0);
`ifdef IDDR_DESER_STATS_EN
    check("t4_word_cnt", word_cnt, 2);
    check("t4_sync_cnt", sync_cnt, 1);
`endif

    // Reset mid-word with a pending output
    do_reset();
    en = 1'b1;
    out_ready = 1'b0;
    send_word(S);
    send_word(8'h3C);
    drive_pair(1'b0, 1'b0);
    drive_pair(1'b1, 1'b1);
    check("t6_pending", out_valid, 1);
    rst_n = 1'b0;
    drive_pair(1'b0, 1'b1);
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_data", out_data, 0);
    check("t6_rst_locked", locked, 0);
    rst_n = 1'b1;

    // Random streams against the bit-stream model
    for (int r = 0; r < 20; r++) begin
      int npre, nw, ntail;
      logic [W-1:0] w;
      do_reset();
      out_ready = 1'b1;
      stream_q.delete();
      exp_words = 0;
      exp_syncs = 0;
      npre = $urandom_range(0, 13);
      for (int i = 0; i < npre; i++) stream_q.push_back(bit'($urandom_range(0, 1)));
      push_word_bits(S);
      nw = $urandom_range(2, 8);
      for (int i = 0; i < nw; i++) begin
        w = ($urandom_range(0, 5) == 0) ? S : W'($urandom);
        push_word_bits(w);
      end
      ntail = $urandom_range(1, 3);
      for (int i = 0; i < ntail; i++) stream_q.push_back(bit'($urandom_range(0, 1)));
      if (stream_q.size() % 2 != 0) stream_q.push_back(1'b0);
      model_stream();
      en = 1'b1;
      for (int i = 0; i < stream_q.size(); i += 2) drive_pair(stream_q[i], stream_q[i+1]);
      en = 1'b0;
      d_rise = 1'b0;
      d_fall = 1'b0;
      repeat (4) tick();
      check("rand_drain", exp_q.size(), 0);
      check("rand_overflow", overflow, 0);
`ifdef IDDR_DESER_STATS_EN
      check("rand_word_cnt", word_cnt, exp_words);
      check("rand_sync_cnt", sync_cnt, exp_syncs);
`endif
    end

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iddr_deser.md
Name: iddr_deser

Overview:
- Input-side counterpart to our ODDR output path.
- Takes the two bits captured per clk by an IDDR primitive: Q0 is the rising-edge bit, Q1 is the falling-edge bit.
- Finds word alignment by hunting for a SYNC pattern at either bit phase, then deserializes the stream into WIDTH-bit words.
- Delivers words on a valid/ready interface to fabric logic, such as LED or status consumers.

Parameters:
- WIDTH, 8, word width in bits; must be even and >= 4.
- SYNC, 8'hA5, WIDTH-bit alignment pattern, MSB first on the wire.

Ports:
- clk  input  1  sole clock; IDDR CLK and all logic run on it.
- rst_n  input  1  synchronous, active-low reset.
- d_rise  input  1  IDDR Q0; bit sampled on the rising edge, earlier on the wire.
- d_fall  input  1  IDDR Q1; bit sampled on the falling edge, later on the wire.
- en  input  1  deserializer enable; low holds the block in HUNT.
- resync  input  1  single-cycle pulse: drop lock, clear overflow, return to HUNT.
- out_data  output  WIDTH  received word, MSB = first bit on the wire.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- locked  output  1  high in LOCKED.
- phase  output  1  locked bit phase: 0 = even, 1 = odd.
- overflow  output  1  sticky; a word was dropped.

Behaviour:
- Reset (rst_n=0 at a clk edge, synchronous): state=HUNT, sr=0, beat=0, out_data=0, out_valid=0, locked=0, phase=0, overflow=0. Reset overrides every other input, including mid-word.
- Shift: every clk with en=1, sr[WIDTH:0] <= {sr[WIDTH-2:0], d_rise, d_fall}. sr is WIDTH+1 bits, so an odd-phase window is available. With en=0, sr holds and state is forced to HUNT.
- Windows: even window wE = sr[WIDTH-1:0]; odd window wO = sr[WIDTH:1].
- HUNT:
  - Evaluated on the registered sr after each shift.
  - If wE==SYNC: go to LOCKED, phase=0, beat=0.
  - Else if wO==SYNC: go to LOCKED, phase=1, beat=0.
  - If both match, the even phase wins.
  - The SYNC word that produced the lock is not emitted.
- LOCKED:
  - beat counts 0..WIDTH/2-1 and increments on every enabled cycle.
  - When beat wraps from WIDTH/2-1 to 0, the selected window (wE if phase=0, wO if phase=1) is a complete word.
  - Complete word == SYNC: the word is discarded as a filler/realign marker; no emit and no state change.
  - Complete word != SYNC: the word is emitted.
- Emit rules:
  - If out_valid=0, or out_valid && out_ready in the same cycle: out_data <= word, out_valid <= 1.
  - If out_valid && !out_ready: the word is dropped, out_data is unchanged, and overflow <= 1.
- Handshake:
  - out_valid && out_ready with no new word in that cycle: out_valid <= 0 on the next edge.
  - out_data is stable while out_valid && !out_ready.
- Latency: the word is emitted one clk after the edge that registers its final bit pair.
- resync=1 (if rst_n=1):
  - state=HUNT, beat=0, overflow=0.
  - out_valid and out_data are untouched; a pending word is still delivered.
  - sr keeps shifting, so SYNC can be detected on the very next cycle.
- Phase and locked update on the same edge as the state change. locked = (state==LOCKED).
- en falling mid-word: the partial word is discarded, beat=0, state=HUNT; a pending output is kept.

Optional Feature:
- Macro: IDDR_DESER_STATS_EN.
- When defined, adds output word_cnt [15:0]:
  - Counts emitted words (drops are excluded).
  - Saturates at 16'hFFFF.
  - Cleared by reset and by resync.
  - Adds output sync_cnt [7:0], counting SYNC words discarded while LOCKED; saturates at 8'hFF and clears the same way.
- When undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset, then en=1 and the even-aligned stream A5,3C,C3 (pairs {1,0},{1,0},{0,1},{0,1},...) -> locked=1, phase=0 after 4 clks; out_data=8'h3C, then 8'hC3, each 4 clks apart; A5 is never emitted.
- One leading pad bit, then A5,5A (odd alignment) -> phase=1, out_data=8'h5A, overflow=0.
- out_ready=0 held while 3C,C3,F0 arrive -> out_data stays 8'h3C; overflow=1 on the second arrival; raise out_ready -> one transfer, then out_valid=0.
- While locked, stream 11,A5,22 -> only 8'h11 and 8'h22 are emitted; with STATS_EN, word_cnt=2 and sync_cnt=1.
- Pulse resync mid-word, then send 00,A5,77 -> locked drops the next cycle, relocks on A5, emits 8'h77, overflow cleared.
- Assert rst_n=0 mid-word while out_valid=1 -> next edge: out_valid=0, out_data=0, locked=0; a pending word is lost by design.
